// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART transmitter and the future
//                UART receiver. Holds the frame-state enumeration, the
//                frame-size limits and an even-parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam int DATA_BITS_MAX = 8;
   localparam int STOP_BITS_MAX = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } uart_state_t;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_BITS_MAX-1:0] d);
      return ^d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Accepts one byte through a valid/ready
//                handshake and sends it as a start bit, DATA_BITS data bits
//                (LSB first), an optional even-parity bit and STOP_BITS stop
//                bits, advancing one bit per baudtick pulse.
//  Config      : define UART_TX_PARITY_EN to compile in the even-parity bit.
//  Ports       : clk       - clock, all state updates on the rising edge
//                rst       - synchronous active-high reset
//                baudtick  - one-cycle pulse per bit period
//                tx_data   - byte to send (bits above DATA_BITS-1 ignored)
//                tx_valid  - tx_data holds a byte to send
//                tx_ready  - block can accept a byte (registered)
//                tx_busy   - frame pending or in progress (registered)
//                tx_done   - one-cycle pulse after the last stop bit
//                tx        - serial line, idles high (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baudtick,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx
);
   import uart_pkg::*;

   localparam logic [7:0] c_DATA_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic [2:0] c_LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       c_LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t r_state;
   logic [7:0]  r_shift;
   logic [2:0]  r_bit_cnt;
   logic        r_stop_cnt;
   logic        r_tx;
   logic        r_ready;
   logic        r_busy;
   logic        r_done;
`ifdef UART_TX_PARITY_EN
   logic        r_parity;
`endif

   logic [7:0]  w_data_masked;
   assign w_data_masked = tx_data & c_DATA_MASK;

   // Outputs are driven as next-state values so that tx changes on the
   // same edge the state does.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shift    <= 8'd0;
         r_bit_cnt  <= 3'd0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // baudtick ignored here; a tick coinciding with acceptance
               // cannot advance ARMED, which only exists from the next edge.
               if (tx_valid && r_ready) begin
                  r_shift <= w_data_masked;
`ifdef UART_TX_PARITY_EN
                  r_parity <= even_parity(w_data_masked);
`endif
                  r_state <= ARMED;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ARMED: begin
               // Wait for a tick so the start bit spans a full bit period.
               if (baudtick) begin
                  r_state <= START;
                  r_tx    <= 1'b0;
               end
            end
            START: begin
               if (baudtick) begin
                  r_state   <= DATA;
                  r_bit_cnt <= 3'd0;
                  r_tx      <= r_shift[0];
               end
            end
            DATA: begin
               if (baudtick) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_cnt == c_LAST_BIT) begin
                     r_bit_cnt  <= 3'd0;
                     r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
                     r_tx    <= r_parity;
`else
                     r_state <= STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baudtick) begin
                  r_state <= STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (baudtick) begin
                  if (r_stop_cnt == c_LAST_STOP) begin
                     r_state <= IDLE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign tx_ready = r_ready;
   assign tx_busy  = r_busy;
   assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Two instances: A (8 data
//                bits, 1 stop) and B (5 data bits, 2 stops). Frames are
//                captured per cycle and compared with a bit list built from
//                the frame rules (start, LSB-first data, optional even
//                parity, stop bits), each bit lasting one baud period.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baudtick = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic       valid_a = 1'b0;
   logic       valid_b = 1'b0;
   logic       ready_a, busy_a, done_a, tx_a;
   logic       ready_b, busy_b, done_b, tx_b;

   int baud = 4;
   int tcnt = 0;
   int n_checks = 0;
   int n_fail = 0;
   logic exp_q[$];

`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   always #5 clk = ~clk;

   // Upstream baud counter stand-in: one-cycle tick every 'baud' cycles.
   always @(posedge clk) begin
      if (tcnt >= baud - 1) begin
         tcnt     <= 0;
         baudtick <= 1'b1;
      end else begin
         tcnt     <= tcnt + 1;
         baudtick <= 1'b0;
      end
   end

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
      .clk(clk), .rst(rst), .baudtick(baudtick), .tx_data(tx_data),
      .tx_valid(valid_a), .tx_ready(ready_a), .tx_busy(busy_a),
      .tx_done(done_a), .tx(tx_a)
   );

   uart_tx #(.DATA_BITS(5), .STOP_BITS(2)) u_dut_b (
      .clk(clk), .rst(rst), .baudtick(baudtick), .tx_data(tx_data),
      .tx_valid(valid_b), .tx_ready(ready_b), .tx_busy(busy_b),
      .tx_done(done_b), .tx(tx_b)
   );

   // Waits for ready (optionally also a tick in the acceptance cycle),
   // presents one byte for one cycle; returns at the negedge after acceptance.
   task automatic accept(input bit b, input logic [7:0] d, input bit on_tick);
      int w = 0;
      @(negedge clk);
      while (!(((b ? ready_b : ready_a) === 1'b1) && (!on_tick || baudtick === 1'b1)) && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (w >= 200) begin
         n_fail++;
         $display("FAIL accept_wait: ready got %b want 1", (b ? ready_b : ready_a));
      end
      tx_data = d;
      if (b) valid_b = 1'b1; else valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
      n_checks++;
      if ((b ? busy_b : busy_a) !== 1'b1 || (b ? ready_b : ready_a) !== 1'b0) begin
         n_fail++;
         $display("FAIL accept_handshake: busy/ready got %b%b want 10",
                  (b ? busy_b : busy_a), (b ? ready_b : ready_a));
      end
   endtask

   // Called at the negedge after acceptance; samples tx every cycle while
   // busy and compares against the expected bit list. exp_arm < 0 means any
   // alignment delay of 1..baud cycles is legal.
   task automatic run_frame(input bit b, input logic [7:0] d, input int exp_arm,
                            input bit inject, input string name);
      logic q[$];
      int db = b ? 5 : 8;
      int sb = b ? 2 : 1;
      int ones = 0;
      int lim, arm, bad;
      bit early = 1'b0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < db; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (PAR) exp_q.push_back(1'((ones % 2)));
      for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
      lim = (exp_q.size() + 1) * baud + 4;
      while ((b ? busy_b : busy_a) === 1'b1 && q.size() < lim) begin
         if ((b ? done_b : done_a) !== 1'b0) early = 1'b1;
         q.push_back(b ? tx_b : tx_a);
         if (inject) begin
            if (q.size() == 2) begin
               tx_data = 8'h3C;
               if (b) valid_b = 1'b1; else valid_a = 1'b1;
            end else if (q.size() == 3) begin
               valid_a = 1'b0;
               valid_b = 1'b0;
            end else if (q.size() == 7) begin
               tx_data = 8'($urandom);
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (q.size() >= lim) begin
         n_fail++;
         $display("FAIL %s_timeout: busy cycles got %0d want < %0d", name, q.size(), lim);
      end
      n_checks++;
      if (early) begin
         n_fail++;
         $display("FAIL %s_done_early: tx_done got 1 want 0 while busy", name);
      end
      n_checks++;
      if ((b ? done_b : done_a) !== 1'b1 || (b ? ready_b : ready_a) !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done_pulse: done/ready got %b%b want 11", name,
                  (b ? done_b : done_a), (b ? ready_b : ready_a));
      end
      arm = q.size() - exp_q.size() * baud;
      n_checks++;
      if (arm < 1 || arm > baud || (exp_arm >= 0 && arm != exp_arm)) begin
         n_fail++;
         $display("FAIL %s_arm: data=%h armed cycles got %0d want %0d (1..%0d), samples %0d",
                  name, d, arm, exp_arm, baud, q.size());
      end else begin
         bad = -1;
         for (int i = 0; i < arm; i++)
            if (bad < 0 && q[i] !== 1'b1) bad = i;
         for (int k = 0; k < exp_q.size(); k++)
            for (int j = 0; j < baud; j++)
               if (bad < 0 && q[arm + k*baud + j] !== exp_q[k]) bad = arm + k*baud + j;
         n_checks++;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s_bits: data=%h sample %0d got %b want %b", name, d, bad, q[bad],
                     (bad < arm) ? 1'b1 : exp_q[(bad - arm) / baud]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_a: tx,ready,busy,done got %b want 1100", {tx_a, ready_a, busy_a, done_a});
      end
      n_checks++;
      if ({tx_b, ready_b, busy_b, done_b} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_b: tx,ready,busy,done got %b want 1100", {tx_b, ready_b, busy_b, done_b});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      baud = 4;
      accept(1'b0, 8'hA5, 1'b0);
      run_frame(1'b0, 8'hA5, -1, 1'b0, "a5");
      @(negedge clk);
      n_checks++;
      if (done_a !== 1'b0) begin
         n_fail++;
         $display("FAIL done_width: tx_done got %b want 0 one cycle after pulse", done_a);
      end
      accept(1'b0, 8'h07, 1'b0);
      run_frame(1'b0, 8'h07, -1, 1'b0, "x07");
   endtask

   task automatic test_tick_align();
      logic [7:0] d = 8'($urandom);
      accept(1'b0, d, 1'b1);
      run_frame(1'b0, d, baud, 1'b0, "tick_align");
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         logic [7:0] d = 8'($urandom);
         bit b = 1'($urandom);
         baud = int'($urandom_range(2, 6));
         repeat (2) @(negedge clk);
         accept(b, d, 1'b0);
         run_frame(b, d, -1, 1'b0, b ? "rand_b" : "rand_a");
      end
      baud = 4;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int w = 0;
      bit seen = 1'b0;
      accept(1'b0, 8'hA5, 1'b0);
      while (tx_a !== 1'b0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      // start bit plus data bits 0..2, then one cycle into bit 3
      repeat (baud * 4 + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_mid: tx,ready,busy,done got %b want 1100", {tx_a, ready_a, busy_a, done_a});
      end
      rst = 1'b0;
      for (int i = 0; i < 3 * baud; i++) begin
         @(negedge clk);
         if (done_a !== 1'b0 || busy_a !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: done/busy after abort got 1 want 0");
      end
      accept(1'b0, 8'h5A, 1'b0);
      run_frame(1'b0, 8'h5A, -1, 1'b0, "after_reset");
   endtask

   task automatic test_ignore_busy();
      bit seen = 1'b0;
      accept(1'b0, 8'h96, 1'b0);
      run_frame(1'b0, 8'h96, -1, 1'b1, "busy_ignore");
      for (int i = 0; i < 3 * baud; i++) begin
         @(negedge clk);
         if (busy_a !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL stale_accept: busy got 1 want 0 after ignored byte");
      end
      accept(1'b0, 8'h11, 1'b0);
      run_frame(1'b0, 8'h11, -1, 1'b0, "x11");
   endtask

   task automatic test_back_to_back();
      int w = 0;
      @(negedge clk);
      while (ready_a !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      tx_data = 8'h55;
      valid_a = 1'b1;
      @(negedge clk);
      tx_data = 8'hAA;
      run_frame(1'b0, 8'h55, -1, 1'b0, "b2b_first");
      // still at the tx_done cycle with valid high: second byte is taken now
      @(negedge clk);
      valid_a = 1'b0;
      run_frame(1'b0, 8'hAA, baud - 1, 1'b0, "b2b_second");
   endtask

   task automatic test_five_bit();
      accept(1'b1, 8'hFF, 1'b0);
      run_frame(1'b1, 8'hFF, -1, 1'b0, "b_ff");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_tick_align();
      test_random();
      test_reset_mid();
      test_ignore_busy();
      test_back_to_back();
      test_five_bit();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
